// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic {SETTLE, PROC} state_e;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = 16;

    typedef struct packed {
        logic       press;
        logic [3:0] code;
    } key_event_t;

    // Active-low one-cold column drive for column c.
    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] c);
        return ~(NUM_COLS'(1) << c);
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Key event store: 4-entry FIFO with KEYPAD_EVENT_FIFO_EN, else a single slot.
// A push while full is accepted only if a pop happens in the same cycle.
module key_event_fifo
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  key_event_t push_data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output key_event_t head_o
);

`ifdef KEYPAD_EVENT_FIFO_EN

    key_event_t mem_q [4];
    logic [1:0] wr_q;
    logic [1:0] rd_q;
    logic [2:0] cnt_q;
    logic       do_push;
    logic       do_pop;

    assign full_o  = (cnt_q == 3'd4);
    assign empty_o = (cnt_q == 3'd0);
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + 2'd1;
            end
            if (do_pop) rd_q <= rd_q + 2'd1;
            cnt_q <= cnt_q + 3'(do_push) - 3'(do_pop);
        end
    end

`else

    key_event_t slot_q;
    logic       valid_q;

    assign full_o  = valid_q;
    assign empty_o = !valid_q;
    assign head_o  = slot_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q  <= '0;
            valid_q <= 1'b0;
        end else if (push_i && (!valid_q || pop_i)) begin
            slot_q  <= push_data_i;
            valid_q <= 1'b1;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
    end

`endif

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: column scan, per-key debounce, press/release events.
// Event store depth is selected by KEYPAD_EVENT_FIFO_EN (4-entry FIFO vs one slot).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int N        = 5000,
    parameter int DEBOUNCE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rows_in,
    output logic [3:0]  cols_out,
    output logic [15:0] keys,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [3:0]  ev_code,
    output logic        ev_press,
    output logic        overflow,
    output logic        frame_tick
);

    localparam int             TW     = $clog2(N);
    localparam logic [TW-1:0]  T_LAST = TW'(N - 1);
    localparam logic [3:0]     DB     = 4'(DEBOUNCE);

    logic [NUM_ROWS-1:0] rows_s1_q;
    logic [NUM_ROWS-1:0] rows_s2_q;
    logic [NUM_ROWS-1:0] row_cap_q;
    logic [NUM_COLS-1:0] cols_out_q;
    state_e              state_q;
    logic [TW-1:0]       timer_q;
    logic [1:0]          col_q;
    logic [1:0]          r_q;
    logic                frame_tick_q;

    logic [NUM_KEYS-1:0] keys_q;
    logic [3:0]          cnt_q [NUM_KEYS];
    logic                overflow_q;

    logic [3:0]          key_idx;
    logic                sample;
    logic [3:0]          cnt_cur;
    logic                flip;
    logic                accept;
    logic                st_full;
    logic                st_empty;
    key_event_t          push_ev;
    key_event_t          head_ev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_s1_q <= '1;
            rows_s2_q <= '1;
        end else begin
            rows_s1_q <= rows_in;
            rows_s2_q <= rows_s1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SETTLE;
            timer_q      <= '0;
            col_q        <= '0;
            r_q          <= '0;
            row_cap_q    <= '1;
            cols_out_q   <= 4'b1110;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= 1'b0;
            unique case (state_q)
                SETTLE: begin
                    if (timer_q == T_LAST) begin
                        row_cap_q <= rows_s2_q;
                        r_q       <= '0;
                        state_q   <= PROC;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                PROC: begin
                    r_q <= r_q + 2'd1;
                    if (r_q == 2'd3) begin
                        col_q        <= col_q + 2'd1;
                        cols_out_q   <= col_drive(col_q + 2'd1);
                        timer_q      <= '0;
                        state_q      <= SETTLE;
                        frame_tick_q <= (col_q == 2'd3);
                    end
                end
                default: state_q <= SETTLE;
            endcase
        end
    end

    assign key_idx = {col_q, r_q};
    assign sample  = ~row_cap_q[r_q];
    assign cnt_cur = cnt_q[key_idx];
    assign accept  = !st_full || (ev_valid && ev_ready);
    assign push_ev = '{press: sample, code: key_idx};

    always_comb begin
        flip = 1'b0;
        if (state_q == PROC && sample != keys_q[key_idx] && cnt_cur + 4'd1 == DB)
            flip = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keys_q     <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
        end else begin
            if (state_q == PROC) begin
                if (sample == keys_q[key_idx]) begin
                    cnt_q[key_idx] <= '0;
                end else if (flip) begin
                    keys_q[key_idx] <= sample;
                    cnt_q[key_idx]  <= '0;
                end else begin
                    cnt_q[key_idx] <= cnt_cur + 4'd1;
                end
            end
            // The key still flips when its event cannot be stored.
            if (flip && !accept) overflow_q <= 1'b1;
        end
    end

    key_event_fifo u_store (
        .clk         (clk),
        .rst         (rst),
        .push_i      (flip),
        .push_data_i (push_ev),
        .pop_i       (ev_valid && ev_ready),
        .full_o      (st_full),
        .empty_o     (st_empty),
        .head_o      (head_ev)
    );

    assign cols_out   = cols_out_q;
    assign keys       = keys_q;
    assign ev_valid   = !st_empty;
    assign ev_code    = head_ev.code;
    assign ev_press   = head_ev.press;
    assign overflow   = overflow_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with N=8, DEBOUNCE=2 (48-cycle frame).
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rows_in;
    logic [3:0]  cols_out;
    logic [15:0] keys;
    logic        ev_valid;
    logic        ev_ready = 1'b1;
    logic [3:0]  ev_code;
    logic        ev_press;
    logic        overflow;
    logic        frame_tick;

    logic [15:0] pressed = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          q_code[$];
    int          q_press[$];
    int          q_cyc[$];

    always #5 clk = ~clk;

    keypad_scanner #(.N(8), .DEBOUNCE(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rows_in    (rows_in),
        .cols_out   (cols_out),
        .keys       (keys),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_press   (ev_press),
        .overflow   (overflow),
        .frame_tick (frame_tick)
    );

    // Switch matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        rows_in = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!cols_out[c] && pressed[c*4+r]) rows_in[r] = 1'b0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ev_valid && ev_ready) begin
            q_code.push_back(int'(ev_code));
            q_press.push_back(int'(ev_press));
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_ev(input string tag, input int idx,
                            input int code, input int press);
        if (idx < q_code.size()) begin
            check({tag, "_code"}, q_code[idx], code);
            check({tag, "_press"}, q_press[idx], press);
        end else begin
            check({tag, "_missing"}, q_code.size(), idx + 1);
        end
    endtask

    task automatic wait_frames(input int n);
        int seen = 0;
        int t = 0;
        while (seen < n && t < 1000) begin
            @(negedge clk);
            t++;
            if (frame_tick) seen++;
        end
        if (seen < n) check("frame_timeout", seen, n);
    endtask

    task automatic clr_q();
        q_code.delete();
        q_press.delete();
        q_cyc.delete();
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        check("rst_cols", cols_out, 4'b1110);
        check("rst_keys", keys, 0);
        check("rst_valid", ev_valid, 0);
        check("rst_code", ev_code, 0);
        check("rst_press", ev_press, 0);
        check("rst_ovf", overflow, 0);
        check("rst_tick", frame_tick, 0);
        rst = 1'b0;

        wait_frames(1);
        t0 = cyc;
        wait_frames(1);
        check("frame_len", cyc - t0, 48);
        @(negedge clk);
        check("tick_pulse", frame_tick, 0);

        // Key 5 press, then release
        wait_frames(1);
        clr_q();
        pressed = 16'h0020;
        wait_frames(1);
        check("k5_early", keys, 0);
        wait_frames(2);
        check("k5_keys", keys, 16'h0020);
        check("k5_nev", q_code.size(), 1);
        check_ev("k5_ev", 0, 5, 1);
        clr_q();
        pressed = '0;
        wait_frames(2);
        check("k5_rel_keys", keys, 0);
        check("k5_rel_nev", q_code.size(), 1);
        check_ev("k5_rel_ev", 0, 5, 0);

        // Key 9 bounce: a single sample only
        clr_q();
        pressed = 16'h0200;
        wait_frames(1);
        pressed = '0;
        wait_frames(3);
        check("k9_keys", keys, 0);
        check("k9_nev", q_code.size(), 0);

        // Keys 0..3 together
        clr_q();
        pressed = 16'h000F;
        wait_frames(2);
        check("col0_keys", keys, 16'h000F);
        check("col0_nev", q_code.size(), 4);
        for (int i = 0; i < 4; i++) check_ev("col0_ev", i, i, 1);
        if (q_cyc.size() == 4) check("col0_span", q_cyc[3] - q_cyc[0], 3);
        pressed = '0;
        wait_frames(2);
        check("col0_rel", keys, 0);
        clr_q();

        // Overflow with consumer stalled
        ev_ready = 1'b0;
        pressed = 16'h1113;
        wait_frames(2);
        check("ovf_keys", keys, 16'h1113);
        check("ovf_flag", overflow, 1);
        check("ovf_valid", ev_valid, 1);
        check("ovf_head_code", ev_code, 0);
        check("ovf_head_press", ev_press, 1);
        check("ovf_nev", q_code.size(), 0);
        ev_ready = 1'b1;
        repeat (10) @(negedge clk);
`ifdef KEYPAD_EVENT_FIFO_EN
        check("drain_nev", q_code.size(), 4);
        check_ev("drain0", 0, 0, 1);
        check_ev("drain1", 1, 1, 1);
        check_ev("drain2", 2, 4, 1);
        check_ev("drain3", 3, 8, 1);
`else
        check("drain_nev", q_code.size(), 1);
        check_ev("drain0", 0, 0, 1);
`endif
        check("drain_valid", ev_valid, 0);
        check("ovf_sticky", overflow, 1);
        wait_frames(1);
        pressed = '0;
        wait_frames(3);
        check("ovf_rel", keys, 0);
        clr_q();

        // Reset mid-PROC with events pending
        ev_ready = 1'b0;
        pressed = 16'h000C;
        wait_frames(2);
        check("pre_rst_keys", keys, 16'h000C);
        check("pre_rst_valid", ev_valid, 1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", ev_valid, 0);
        check("mid_rst_keys", keys, 0);
        check("mid_rst_cols", cols_out, 4'b1110);
        check("mid_rst_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        ev_ready = 1'b1;
        clr_q();
        wait_frames(1);
        check("re_early", keys, 0);
        wait_frames(1);
        check("re_keys", keys, 16'h000C);
        check("re_nev", q_code.size(), 2);
        check_ev("re_ev0", 0, 2, 1);
        check_ev("re_ev1", 1, 3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4×4 passive key matrix and turns it into debounced key state plus a serialized press/release event stream. It is the input-side counterpart of the LED matrix driver: it drives one column at a time and reads the rows back, rather than driving rows for display. Typical placement is beside the LED matrix on the icefun board, feeding a top-level consumer over a valid/ready event port.

## Interface
- `N`, default 5_000: clocks of column dwell/settle before the rows are sampled; N ≥ 4.
- `DEBOUNCE`, default 3: consecutive differing samples (one sample per frame) needed to flip a key; range 1–15.
- `clk`, in, 1: system clock, 12 MHz.
- `rst`, in, 1: reset, asynchronous, active-high.
- `rows_in`, in, 4: matrix rows, active-low (external pull-ups); asynchronous to `clk`.
- `cols_out`, out, 4: column drive, active-low, exactly one bit low at any time.
- `keys`, out, 16: debounced key state, bit k = col*4+row, 1 = pressed.
- `ev_valid`, out, 1: event available.
- `ev_ready`, in, 1: consumer accepts event.
- `ev_code`, out, 4: key index of the event.
- `ev_press`, out, 1: 1 = press, 0 = release.
- `overflow`, out, 1: sticky flag, set when an event was dropped.
- `frame_tick`, out, 1: one-cycle pulse after column 3 is processed.

## Operation
- `rows_in` passes through a 2-FF synchronizer before any use.
- FSM, two states:
  - SETTLE: timer counts 0..N-1. At N-1, the synchronized rows are latched into `row_cap`, and the FSM goes to PROC with r=0.
  - PROC: lasts 4 cycles, r = 0..3, and handles key k = col*4+r each cycle. After r=3, col advances (3 wraps to 0), timer clears, and the FSM returns to SETTLE.
  - `cols_out` changes only on the PROC→SETTLE transition.
- Per-key debounce counter, 4 bits. Sample s = ~row_cap[r].
  - If s == keys[k]: count ← 0.
  - Else, if count+1 == DEBOUNCE: keys[k] ← s, count ← 0, push event {code=k, press=s}.
  - Else: count ← count+1.
- At most one push per cycle, so events within a column are ordered by row 0..3. Columns are ordered 0..3.
- Push is accepted when the event store is not full, or when a pop (`ev_valid && ev_ready`) happens the same cycle. Otherwise the event is dropped, `overflow` ← 1, and `keys` is still updated.
- `overflow` clears only on reset.
- Timer width is clog2(N). No arithmetic overflow is possible on the timer or the counters.

## Timing
- Frame = 4·(N+4) cycles. Per-key detection latency is DEBOUNCE frames, plus up to one frame of phase.
- `keys[k]` updates on the clock edge ending the PROC cycle for k.
- `ev_valid` rises on that same edge, with zero bubble when the store is empty. Data holds stable until the cycle after `ev_valid && ev_ready`.
- `frame_tick` is high for the single cycle after the PROC r=3, col=3 edge.
- Reset values:
  - `cols_out` = 4'b1110, state SETTLE, timer 0, col 0.
  - `keys` = 0, all counters 0, store empty.
  - `ev_valid` = 0, `ev_code` = 0, `ev_press` = 0, `overflow` = 0, `frame_tick` = 0.
- Reset mid-frame or with events pending discards all pending events and debounce history. Keys still held are re-reported as presses after DEBOUNCE frames.

## Configuration
- `KEYPAD_EVENT_FIFO_EN` defined: the event store is a 4-entry FIFO. Full means 4 entries held.
- `KEYPAD_EVENT_FIFO_EN` undefined: the event store is a single register slot. Full means `ev_valid` is high.
- Ports and handshake are identical in both builds.

## Structure
- `keypad_pkg` holds:
  - the state enum {SETTLE, PROC};
  - constants NUM_ROWS=4, NUM_COLS=4, NUM_KEYS=16;
  - the event struct {press, code[3:0]}.
- Sub-module `key_event_fifo`: push/pop with full/empty flags, depth selected by the macro (1 or 4).

## Test plan
Bench parameters: N=8, DEBOUNCE=2, so frame = 48 cycles. The bench emulates a switch matrix by setting row r low while `cols_out[c]`=0.
- Key 5 (col 1, row 1) held for 3 frames, `ev_ready`=1 → `keys`=16'h0020; exactly one event {code 5, press 1}. On release, after 2 frames → `keys`=0 and one event {5, 0}.
- Key 9 asserted for 1 frame only (bounce) → no event, `keys` stays 0.
- Keys 0–3 pressed together → events for codes 0, 1, 2, 3 on consecutive cycles in the same frame; `keys`=16'h000F.
- `ev_ready`=0, press keys 0, 4, 8, 12, 1 → FIFO build holds 4 events and the fifth is dropped, `overflow`=1; single-slot build holds {0, 1}, `overflow`=1. Then `ev_ready`=1 drains the held events in order; `overflow` stays 1.
- `rst` pulsed mid-PROC with 2 events queued → `ev_valid`=0, `keys`=0, `cols_out`=4'b1110 immediately. A key still held is re-reported 2 frames later.
